// File: rtl/div_repsub_pkg.sv
// Shared definitions for the repeated-subtraction divider: default width and
// controller state encoding.
package div_repsub_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LDB  = 2'd1,
        ST_SUB  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/div_repsub_dp.sv
// Divider datapath: remainder register, divisor register, quotient counter,
// the remainder >= divisor comparator and the divisor zero detector.
module div_repsub_dp
    import div_repsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load_a,
    input  logic             i_load_b,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo,
    output logic             o_ge,
    output logic             o_div_zero
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = WIDTH'(0);

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;

    // Remainder/quotient: load dividend and clear count, or take one subtraction step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem <= ZERO;
            r_quo <= ZERO;
        end else if (i_load_a) begin
            r_rem <= i_data;
            r_quo <= ZERO;
        end else if (i_step) begin
            r_rem <= r_rem - r_div;
            r_quo <= r_quo + ONE;
        end
    end

    // Divisor register, captured from the shared operand bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= ZERO;
        end else if (i_load_b) begin
            r_div <= i_data;
        end
    end

    assign o_rem      = r_rem;
    assign o_quo      = r_quo;
    assign o_ge       = (r_rem >= r_div);
    assign o_div_zero = (r_div == ZERO);

endmodule

// File: rtl/div_repsub.sv
// Sequential unsigned divider by repeated subtraction. Dividend then divisor
// arrive on data_in in consecutive cycles; the FSM steers the datapath.
module div_repsub
    import div_repsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    state_t r_state;
    logic   r_busy;
    logic   r_done;
    logic   r_dbz;

    logic   w_load_a;
    logic   w_load_b;
    logic   w_step;
    logic   w_ge;
    logic   w_div_zero;

    // Datapath controls decoded from the current state.
    always_comb begin
        w_load_a = 1'b0;
        w_load_b = 1'b0;
        w_step   = 1'b0;
        case (r_state)
            ST_IDLE: w_load_a = start;
            ST_LDB:  w_load_b = 1'b1;
            ST_SUB:  w_step   = (!w_div_zero) && w_ge;
            default: w_step   = 1'b0;
        endcase
    end

    div_repsub_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load_a   (w_load_a),
        .i_load_b   (w_load_b),
        .i_step     (w_step),
        .i_data     (data_in),
        .o_rem      (remainder),
        .o_quo      (quotient),
        .o_ge       (w_ge),
        .o_div_zero (w_div_zero)
    );

    // Controller FSM with registered busy/done/div_by_zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_LDB;
                        r_busy  <= 1'b1;
                        r_dbz   <= 1'b0;
                    end
                end
                ST_LDB: begin
                    r_state <= ST_SUB;
                end
                ST_SUB: begin
                    // Zero divisor wins over the comparator, which would otherwise loop forever.
                    if (w_div_zero) begin
                        r_dbz   <= 1'b1;
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else if (!w_ge) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_repsub.sv
// Directed self-checking bench for div_repsub: reset, exact/inexact division,
// divide-by-zero, width boundaries, protocol corner cases and random operands.
module tb_div_repsub;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] data_in;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [15:0] quotient;
    logic [15:0] remainder;

    int n_cmp;
    int n_err;

    div_repsub #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .data_in     (data_in),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch a divide; returns the cycle index (start cycle = 0) at which done
    // is seen, or -1 if it never arrives. Optionally pulses start with 7 on
    // data_in during cycle poke. Returns at the negedge inside the done cycle.
    task automatic run_div(input logic [15:0] a, input logic [15:0] b,
                           input int poke, output int lat);
        bit found;
        @(negedge clk);
        start   = 1'b1;
        data_in = a;
        @(negedge clk);
        start   = 1'b0;
        data_in = b;
        lat     = 1;
        found   = 1'b0;
        while (!found && lat < 70000) begin
            if (done === 1'b1) begin
                found = 1'b1;
            end else begin
                start   = (lat == poke);
                data_in = (lat == poke) ? 16'd7 : b;
                @(negedge clk);
                lat++;
            end
        end
        start = 1'b0;
        if (!found) lat = -1;
    endtask

    task automatic test_reset();
        int lat;
        rst_n   = 1'b0;
        start   = 1'b0;
        data_in = 16'd0;
        #12;
        n_cmp++;
        if ({busy, done, div_by_zero, quotient, remainder} !== 35'd0) begin
            n_err++;
            $display("FAIL reset_init: got busy=%b done=%b dbz=%b q=%0d r=%0d want all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start   = 1'b1;
        data_in = 16'd100;
        @(negedge clk);
        start   = 1'b0;
        data_in = 16'd3;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, div_by_zero, quotient, remainder} !== 35'd0) begin
            n_err++;
            $display("FAIL reset_mid: got busy=%b done=%b dbz=%b q=%0d r=%0d want all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_div(16'd100, 16'd3, -1, lat);
        n_cmp++;
        if (lat !== 36 || quotient !== 16'd33 || remainder !== 16'd1) begin
            n_err++;
            $display("FAIL reset_rerun: got lat=%0d q=%0d r=%0d want lat=36 q=33 r=1",
                     lat, quotient, remainder);
        end
    endtask

    task automatic test_exact();
        int lat;
        run_div(16'd48, 16'd6, -1, lat);
        n_cmp++;
        if (lat !== 11 || quotient !== 16'd8 || remainder !== 16'd0 || div_by_zero !== 1'b0) begin
            n_err++;
            $display("FAIL exact_48_6: got lat=%0d q=%0d r=%0d dbz=%b want lat=11 q=8 r=0 dbz=0",
                     lat, quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL done_width: got done=%b busy=%b after done cycle want 0 0", done, busy);
        end
    endtask

    task automatic test_small();
        int lat;
        run_div(16'd5, 16'd9, -1, lat);
        n_cmp++;
        if (lat !== 3 || quotient !== 16'd0 || remainder !== 16'd5) begin
            n_err++;
            $display("FAIL less_5_9: got lat=%0d q=%0d r=%0d want lat=3 q=0 r=5",
                     lat, quotient, remainder);
        end
        run_div(16'd7, 16'd7, -1, lat);
        n_cmp++;
        if (lat !== 4 || quotient !== 16'd1 || remainder !== 16'd0) begin
            n_err++;
            $display("FAIL equal_7_7: got lat=%0d q=%0d r=%0d want lat=4 q=1 r=0",
                     lat, quotient, remainder);
        end
    endtask

    task automatic test_div_zero();
        int lat;
        run_div(16'd1234, 16'd0, -1, lat);
        n_cmp++;
        if (lat !== 3 || div_by_zero !== 1'b1 || quotient !== 16'd0 || remainder !== 16'd1234) begin
            n_err++;
            $display("FAIL div_zero: got lat=%0d dbz=%b q=%0d r=%0d want lat=3 dbz=1 q=0 r=1234",
                     lat, div_by_zero, quotient, remainder);
        end
        @(negedge clk);
        n_cmp++;
        if (div_by_zero !== 1'b1) begin
            n_err++;
            $display("FAIL dbz_hold: got dbz=%b want 1", div_by_zero);
        end
        run_div(16'd10, 16'd2, -1, lat);
        n_cmp++;
        if (lat !== 8 || div_by_zero !== 1'b0 || quotient !== 16'd5 || remainder !== 16'd0) begin
            n_err++;
            $display("FAIL dbz_clear: got lat=%0d dbz=%b q=%0d r=%0d want lat=8 dbz=0 q=5 r=0",
                     lat, div_by_zero, quotient, remainder);
        end
    endtask

    task automatic test_boundary();
        int lat;
        run_div(16'hFFFF, 16'd1, -1, lat);
        n_cmp++;
        if (lat !== 65538 || quotient !== 16'hFFFF || remainder !== 16'd0) begin
            n_err++;
            $display("FAIL max_by_1: got lat=%0d q=%0d r=%0d want lat=65538 q=65535 r=0",
                     lat, quotient, remainder);
        end
        run_div(16'hFFFF, 16'hFFFF, -1, lat);
        n_cmp++;
        if (lat !== 4 || quotient !== 16'd1 || remainder !== 16'd0) begin
            n_err++;
            $display("FAIL max_by_max: got lat=%0d q=%0d r=%0d want lat=4 q=1 r=0",
                     lat, quotient, remainder);
        end
    endtask

    task automatic test_protocol();
        int lat;
        run_div(16'd100, 16'd3, 5, lat);
        n_cmp++;
        if (lat !== 36 || quotient !== 16'd33 || remainder !== 16'd1) begin
            n_err++;
            $display("FAIL start_in_sub: got lat=%0d q=%0d r=%0d want lat=36 q=33 r=1",
                     lat, quotient, remainder);
        end
        // start only in the DONE cycle, dropped in the following IDLE cycle
        start   = 1'b1;
        data_in = 16'd200;
        @(negedge clk);
        start   = 1'b0;
        data_in = 16'd5;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== 16'd33 || remainder !== 16'd1) begin
            n_err++;
            $display("FAIL idle_hold: got busy=%b done=%b q=%0d r=%0d want 0 0 q=33 r=1",
                     busy, done, quotient, remainder);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        run_div(16'd60, 16'd7, -1, lat);
        n_cmp++;
        if (lat !== 11 || quotient !== 16'd8 || remainder !== 16'd4) begin
            n_err++;
            $display("FAIL b2b_first: got lat=%0d q=%0d r=%0d want lat=11 q=8 r=4",
                     lat, quotient, remainder);
        end
        run_div(16'd9, 16'd4, -1, lat);
        n_cmp++;
        if (lat !== 5 || quotient !== 16'd2 || remainder !== 16'd1) begin
            n_err++;
            $display("FAIL b2b_second: got lat=%0d q=%0d r=%0d want lat=5 q=2 r=1",
                     lat, quotient, remainder);
        end
    endtask

    task automatic test_random();
        int lat;
        logic [15:0] a;
        logic [15:0] b;
        int unsigned eq;
        int unsigned er;
        for (int i = 0; i < 8; i++) begin
            a  = 16'($urandom_range(0, 65535));
            b  = 16'($urandom_range(200, 65535));
            eq = 32'(a) / 32'(b);
            er = 32'(a) % 32'(b);
            run_div(a, b, -1, lat);
            n_cmp++;
            if (lat !== int'(eq) + 3 || 32'(quotient) !== eq || 32'(remainder) !== er ||
                (32'(quotient) * 32'(b) + 32'(remainder)) !== 32'(a) || remainder >= b) begin
                n_err++;
                $display("FAIL random_%0d: %0d/%0d got lat=%0d q=%0d r=%0d want lat=%0d q=%0d r=%0d",
                         i, a, b, lat, quotient, remainder, eq + 3, eq, er);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_exact();
        test_small();
        test_div_zero();
        test_boundary();
        test_protocol();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
